// File: rtl/aes_byte_host_adapter.sv
// aes_byte_host_adapter: host-side master for a byte-serial AES core.
// Takes one 128-bit key/plaintext request, clears the core, streams the
// key and block MSB-byte-first, collects 16 result bytes LSB-byte-first and
// returns the assembled ciphertext (or an error status) over an output
// valid/ready handshake. Every output comes straight from a flop.

module aes_byte_host_adapter #(
  parameter int unsigned CLEAR_CYCLES   = 2,    // 1..15
  parameter int unsigned TIMEOUT_CYCLES = 1023  // 1..65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         out_err,
  output logic         core_rst,
  output logic         core_enable,
  output logic [7:0]   core_key_byte,
  output logic [7:0]   core_state_byte,
  input  logic         core_load,
  input  logic         core_ready,
  input  logic [7:0]   core_state_out_byte
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COLLECT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [3:0]  CLR_LAST = 4'(CLEAR_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  blk_q, blk_d;
  logic [127:0]  res_q, res_d;
  logic [3:0]    clr_q, clr_d;
  logic [3:0]    k_q, k_d;
  logic [4:0]    n_q, n_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          err_q, err_d;

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [127:0]  out_block_q, out_block_d;
  logic          out_err_q, out_err_d;
  logic          core_rst_q, core_rst_d;
  logic          core_enable_q, core_enable_d;
  logic [7:0]    key_byte_q, key_byte_d;
  logic [7:0]    state_byte_q, state_byte_d;

  // core_load is an informational strobe from the core; control never uses it.
  logic          core_load_unused;
  assign core_load_unused = core_load;

  // Byte idx counted from the most significant end (idx 0 -> bits [127:120]).
  function automatic logic [7:0] msb_byte(input logic [127:0] v, input logic [3:0] idx);
    logic [127:0] sh;
    sh = v << {idx, 3'b000};
    return sh[127:120];
  endfunction

  // Next-state and datapath update for the request/load/collect sequence.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    blk_d   = blk_q;
    res_d   = res_q;
    clr_d   = clr_q;
    k_d     = k_q;
    n_d     = n_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          key_d   = in_key;
          blk_d   = in_block;
          res_d   = 128'd0;
          err_d   = 1'b0;
          clr_d   = 4'd0;
          k_d     = 4'd0;
          n_d     = 5'd0;
          tmo_d   = 16'd0;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_q >= CLR_LAST) begin
          k_d     = 4'd0;
          state_d = ST_LOAD;
        end else begin
          clr_d = clr_q + 4'd1;
        end
      end
      ST_LOAD: begin
        if (k_q == 4'd15) begin
          tmo_d   = 16'd0;
          state_d = ST_WAIT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_WAIT: begin
        // A result byte in the last allowed cycle still wins over the timeout.
        if (core_ready) begin
          res_d[7:0] = core_state_out_byte;
          n_d        = 5'd1;
          state_d    = ST_COLLECT;
        end else if (tmo_q >= TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_COLLECT: begin
        // Once all 16 bytes are in, any further core_ready is ignored.
        if (n_q >= 5'd16) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (core_ready) begin
          res_d[{n_q[3:0], 3'b000} +: 8] = core_state_out_byte;
          n_d = n_q + 5'd1;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready && out_valid_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    in_ready_d    = (state_d == ST_IDLE);
    out_valid_d   = (state_d == ST_DONE);
    out_block_d   = 128'd0;
    out_err_d     = 1'b0;
    core_rst_d    = 1'b0;
    core_enable_d = 1'b0;
    key_byte_d    = 8'd0;
    state_byte_d  = 8'd0;
    case (state_d)
      ST_IDLE: begin
        core_rst_d = 1'b0;
      end
      ST_CLEAR: begin
        core_rst_d = 1'b1;
      end
      ST_LOAD: begin
        core_enable_d = 1'b1;
        key_byte_d    = msb_byte(key_d, k_d);
        state_byte_d  = msb_byte(blk_d, k_d);
      end
      ST_WAIT, ST_COLLECT: begin
        core_enable_d = 1'b1;
      end
      ST_DONE: begin
        core_rst_d  = 1'b1;
        out_block_d = res_d;
        out_err_d   = err_d;
      end
      default: begin
        core_rst_d = 1'b1;
      end
    endcase
  end

  // FSM state, request holding registers and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      key_q   <= 128'd0;
      blk_q   <= 128'd0;
      res_q   <= 128'd0;
      clr_q   <= 4'd0;
      k_q     <= 4'd0;
      n_q     <= 5'd0;
      tmo_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      clr_q   <= clr_d;
      k_q     <= k_d;
      n_q     <= n_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Registered copies of every output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_block_q   <= 128'd0;
      out_err_q     <= 1'b0;
      core_rst_q    <= 1'b1;
      core_enable_q <= 1'b0;
      key_byte_q    <= 8'd0;
      state_byte_q  <= 8'd0;
    end else begin
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_block_q   <= out_block_d;
      out_err_q     <= out_err_d;
      core_rst_q    <= core_rst_d;
      core_enable_q <= core_enable_d;
      key_byte_q    <= key_byte_d;
      state_byte_q  <= state_byte_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_block       = out_block_q;
  assign out_err         = out_err_q;
  assign core_rst        = core_rst_q;
  assign core_enable     = core_enable_q;
  assign core_key_byte   = key_byte_q;
  assign core_state_byte = state_byte_q;

endmodule

// File: tb/tb_aes_byte_host_adapter.sv
// Bench for aes_byte_host_adapter: a scripted core stand-in plus a timeline
// model (phase boundaries computed from clear length, wait time and burst
// length) checked against the DUT on every negative clock edge.

module tb_aes_byte_host_adapter;

  localparam int C = 2;
  localparam int T = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_key = 128'd0;
  logic [127:0] in_block = 128'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         out_err;
  logic         core_rst;
  logic         core_enable;
  logic [7:0]   core_key_byte;
  logic [7:0]   core_state_byte;
  logic         core_load = 1'b0;
  logic         core_ready = 1'b0;
  logic [7:0]   core_state_out_byte = 8'd0;

  aes_byte_host_adapter #(.CLEAR_CYCLES(C), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .out_err(out_err),
    .core_rst(core_rst), .core_enable(core_enable),
    .core_key_byte(core_key_byte), .core_state_byte(core_state_byte),
    .core_load(core_load), .core_ready(core_ready), .core_state_out_byte(core_state_out_byte)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_busy = 1'b0;
  bit m_fresh = 1'b1;
  int acc_cyc = 0;
  int acc_count = 0;

  // configuration for the next request the core stand-in will serve
  int         cfg_w = 0;
  int         cfg_nb = 0;
  logic [7:0] cfg_bytes [0:17];
  // transaction in flight
  int           tx_w, tx_nb, tx_done;
  logic [7:0]   tx_bytes [0:17];
  logic [127:0] tx_key, tx_blk, tx_res;
  logic         tx_err;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_cfg(input int w, input int nb, input logic [127:0] src);
    cfg_w = w;
    cfg_nb = nb;
    for (int i = 0; i < 16; i++) cfg_bytes[i] = src[8*i +: 8];
    cfg_bytes[16] = 8'hEE;
    cfg_bytes[17] = 8'hEF;
  endtask

  // Model: accept / handshake bookkeeping; result and timeline of each request.
  always @(posedge clk) begin
    if (rst) begin
      if (m_busy) begin
        if ((cyc - acc_cyc) >= tx_done && out_ready) m_busy = 1'b0;
      end else if (in_valid) begin
        m_busy = 1'b1;
        acc_cyc = cyc + 1;
        acc_count++;
        tx_key = in_key;
        tx_blk = in_block;
        tx_w = cfg_w;
        tx_nb = cfg_nb;
        for (int i = 0; i < 18; i++) tx_bytes[i] = cfg_bytes[i];
        if (tx_w >= T || tx_nb == 0) tx_done = C + 16 + T;
        else if (tx_nb >= 16)        tx_done = C + 16 + tx_w + 16 + 1;
        else                         tx_done = C + 16 + tx_w + tx_nb + 1;
        tx_err = !(tx_w < T && tx_nb >= 16);
        tx_res = 128'd0;
        for (int i = 0; i < 16; i++)
          if (tx_w < T && i < tx_nb) tx_res[8*i +: 8] = tx_bytes[i];
      end
      m_fresh = 1'b0;
    end
    cyc = cyc + 1;
  end

  always @(negedge rst) begin
    m_busy = 1'b0;
    m_fresh = 1'b1;
  end

  // Core stand-in: result bytes start tx_w cycles into WAIT.
  always @(posedge clk) begin
    int r, i;
    #1;
    core_ready = 1'b0;
    core_state_out_byte = 8'd0;
    core_load = 1'b0;
    if (m_busy) begin
      r = cyc - acc_cyc;
      i = r - (C + 16 + tx_w);
      if (r >= C && r < C + 16) core_load = 1'b1;
      if (i >= 0 && i < tx_nb) begin
        core_ready = 1'b1;
        core_state_out_byte = tx_bytes[i];
      end
    end
  end

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    int r;
    logic e_rdy, e_ov, e_rst, e_en;
    logic [7:0] e_kb, e_sb;
    e_kb = 8'd0; e_sb = 8'd0; e_ov = 1'b0; e_en = 1'b0;
    if (!rst) begin
      e_rdy = 1'b1;
      e_rst = 1'b1;
      chk("rst_out_block", out_block, 128'd0);
      chk("rst_out_err", out_err, 1'b0);
    end else if (!m_busy) begin
      e_rdy = 1'b1;
      e_rst = m_fresh;
    end else begin
      r = cyc - acc_cyc;
      e_rdy = 1'b0;
      e_rst = 1'b0;
      if (r < C) begin
        e_rst = 1'b1;
      end else if (r < C + 16) begin
        e_en = 1'b1;
        e_kb = tx_key[127 - 8*(r - C) -: 8];
        e_sb = tx_blk[127 - 8*(r - C) -: 8];
      end else if (r < tx_done) begin
        e_en = 1'b1;
      end else begin
        e_rst = 1'b1;
        e_ov = 1'b1;
        chk("m_out_block", out_block, tx_res);
        chk("m_out_err", out_err, tx_err);
      end
    end
    chk("m_in_ready", in_ready, e_rdy);
    chk("m_out_valid", out_valid, e_ov);
    chk("m_core_rst", core_rst, e_rst);
    chk("m_core_enable", core_enable, e_en);
    chk("m_core_key_byte", core_key_byte, e_kb);
    chk("m_core_state_byte", core_state_byte, e_sb);
  end

  task automatic start(input logic [127:0] k, input logic [127:0] b, input bit hold);
    int c0;
    c0 = acc_count;
    in_key = k;
    in_block = b;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && acc_count == c0; n++) begin
      @(posedge clk); #2;
    end
    chk("accept_seen", 128'(acc_count != c0), 128'd1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat, input logic [127:0] exp_blk, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", out_valid, 1'b1);
    chk("latency", cyc - acc_cyc, exp_lat);
    chk("out_block", out_block, exp_blk);
    chk("out_err", out_err, exp_err);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    chk("idle_after_hs", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fk, fb, fct, pat, shrt;
    int a1, c0, ovc;
    logic [7:0] kk;
    fk   = 128'h000102030405060708090a0b0c0d0e0f;
    fb   = 128'h00112233445566778899aabbccddeeff;
    fct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pat  = 128'h0f0e0d0c0b0a09080706050403020100;
    shrt = 128'hffffffffffffffffffa6a5a4a3a2a1a0;

    // reset, then idle
    repeat (3) @(negedge clk);
    chk("reset_core_rst", core_rst, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_core_rst", core_rst, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);

    // FIPS-197 request: load byte order and returned ciphertext
    set_cfg(3, 18, fct);
    start(fk, fb, 1'b0);
    @(negedge clk);
    repeat (C) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      kk = 8'(k);
      chk("fips_load_key", core_key_byte, kk);
      chk("fips_load_blk", core_state_byte, {kk[3:0], kk[3:0]});
      @(negedge clk);
    end
    wait_valid(38, fct, 1'b0);
    handshake();

    // bytes 00..0f with W=5
    set_cfg(5, 16, pat);
    start(128'h1, 128'h2, 1'b0);
    wait_valid(40, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
    handshake();

    // core never answers
    set_cfg(100, 0, pat);
    start(128'h3, 128'h4, 1'b0);
    wait_valid(38, 128'd0, 1'b1);
    handshake();

    // short burst of 7 bytes, host stalls 10 cycles
    set_cfg(3, 7, shrt);
    start(128'h5, 128'h6, 1'b0);
    wait_valid(29, 128'h000000000000000000a6a5a4a3a2a1a0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_block", out_block, 128'h000000000000000000a6a5a4a3a2a1a0);
      chk("stall_err", out_err, 1'b1);
    end
    handshake();

    // first byte in the last WAIT cycle before timeout
    set_cfg(T - 1, 16, 128'hdeadbeef0123456789abcdef55aa33cc);
    start(128'h7, 128'h8, 1'b0);
    wait_valid(54, 128'hdeadbeef0123456789abcdef55aa33cc, 1'b0);
    handshake();

    // back-to-back with in_valid held high
    set_cfg(5, 16, pat);
    out_ready = 1'b1;
    start(fk, fb, 1'b1);
    a1 = acc_cyc;
    c0 = acc_count;
    in_key = 128'h9;
    in_block = 128'ha;
    set_cfg(2, 16, fct);
    for (int n = 0; n < 150 && acc_count == c0; n++) begin
      @(posedge clk); #2;
    end
    chk("b2b_gap", acc_cyc - a1, 42);
    in_valid = 1'b0;
    wait_valid(37, fct, 1'b0);
    @(posedge clk); #2;
    out_ready = 1'b0;

    // reset in the middle of LOAD
    set_cfg(5, 16, pat);
    start(fk, fb, 1'b0);
    repeat (C + 5) @(negedge clk);
    chk("pre_abort_enable", core_enable, 1'b1);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_enable", core_enable, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    ovc = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid === 1'b1) ovc++;
    end
    chk("abort_no_result", ovc, 0);

    // recovery request after the abort
    set_cfg(4, 16, pat);
    start(fk, fb, 1'b0);
    wait_valid(39, pat, 1'b0);
    handshake();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
